pc_sequencer: RTL and testbench

- Parametrised, synchronous program-counter sequencer for the instruction-fetch stage.
- Generalises the single-source PC (hold / increment / load). Adds parametrised address width and reset vector, an exception redirect with fixed priority, and a circular return-address stack (RAS) for call/return prediction.
- Sits between the control/branch unit and instruction memory. The `pc` output drives the IM address directly.

---
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for instruction fetch: hold / increment / load,
// exception redirect, and a circular return-address stack for call/return.
module pc_sequencer #(
   parameter int unsigned       ADDR_W    = 10,
   parameter int unsigned       RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(10'h3F0)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              exc,
   input  logic              load_pc,
   input  logic [ADDR_W-1:0] pc_new,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_4,
   output logic [ADDR_W-1:0] ras_top,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_udf
);

   localparam int unsigned      PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
   logic [PTR_W-1:0]  top_q, top_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              push_we;

   assign pc        = pc_q;
   assign pc_4      = pc_q + ADDR_W'(1);
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_MAX);
   assign ras_top   = ras_empty ? '0 : stack_q[top_q];
   assign ras_ovf   = ovf_q;
   assign ras_udf   = udf_q;

   // top_q always names the newest entry; a full push simply advances it and
   // lands on the oldest slot, so the count saturates while LIFO order holds.
   always_comb begin
      pc_d    = pc_q;
      top_d   = top_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      push_we = 1'b0;
      if (en) begin
         if (exc) begin
            pc_d  = EXC_VEC;
            cnt_d = '0;
         end else if (load_pc) begin
            pc_d = pc_new;
            if (call) begin
               push_we = 1'b1;
               top_d   = top_q + PTR_W'(1);
               if (ras_full) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end else if (ret) begin
            if (!ras_empty) begin
               pc_d  = stack_q[top_q];
               top_d = top_q - PTR_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               pc_d  = pc_4;
               udf_d = 1'b1;
            end
         end else begin
            pc_d = pc_4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VEC;
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         pc_q  <= pc_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         if (push_we) begin
            stack_q[top_d] <= pc_4;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, run, stall, call/return, overflow,
// underflow, priority, wrap and mid-sequence reset.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst, en, exc, load_pc, call, ret;
   logic [9:0] pc_new;
   logic [9:0] pc, pc_4, ras_top;
   logic       ras_empty, ras_full, ras_ovf, ras_udf;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.ADDR_W(10), .RAS_DEPTH(4), .RESET_VEC(10'h000), .EXC_VEC(10'h3F0)) dut (
      .clk(clk), .rst(rst), .en(en), .exc(exc), .load_pc(load_pc), .pc_new(pc_new),
      .call(call), .ret(ret), .pc(pc), .pc_4(pc_4), .ras_top(ras_top),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; en = 1'b1; exc = 1'b0; load_pc = 1'b0; call = 1'b0; ret = 1'b0; pc_new = '0;
   endtask

   task automatic jump(input logic [9:0] target, input logic is_call);
      idle(); load_pc = 1'b1; call = is_call; pc_new = target; step(); idle();
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1; step(); idle();
      checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got %h expected %h", pc, 10'h000); end
      checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b expected 1 0", ras_empty, ras_full); end
      checks++; if (ras_top !== 10'h000) begin errors++; $display("FAIL reset_top got %h expected 000", ras_top); end
      checks++; if (ras_ovf !== 1'b0 || ras_udf !== 1'b0) begin errors++; $display("FAIL reset_sticky got ovf=%b udf=%b expected 0 0", ras_ovf, ras_udf); end
   endtask

   task automatic test_run();
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (pc !== 10'(i)) begin errors++; $display("FAIL run_pc got %h expected %h", pc, 10'(i)); end
      end
      checks++; if (pc_4 !== 10'h004) begin errors++; $display("FAIL run_pc4 got %h expected 004", pc_4); end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL run_empty got %b expected 1", ras_empty); end
   endtask

   task automatic test_stall();
      step(); step();
      checks++; if (pc !== 10'h005) begin errors++; $display("FAIL stall_pre got %h expected 005", pc); end
      en = 1'b0; load_pc = 1'b1; pc_new = 10'h040;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (pc !== 10'h005) begin errors++; $display("FAIL stall_hold got %h expected 005", pc); end
      end
      idle(); step();
      checks++; if (pc !== 10'h006) begin errors++; $display("FAIL stall_resume got %h expected 006", pc); end
   endtask

   task automatic test_call_ret();
      jump(10'h010, 1'b0);
      jump(10'h080, 1'b1);
      checks++; if (pc !== 10'h080) begin errors++; $display("FAIL call_pc got %h expected 080", pc); end
      checks++; if (ras_top !== 10'h011 || ras_empty !== 1'b0) begin errors++; $display("FAIL call_top got %h empty=%b expected 011 0", ras_top, ras_empty); end
      step(); step();
      checks++; if (pc !== 10'h082) begin errors++; $display("FAIL call_idle got %h expected 082", pc); end
      ret = 1'b1; step(); idle();
      checks++; if (pc !== 10'h011) begin errors++; $display("FAIL ret_pc got %h expected 011", pc); end
      checks++; if (ras_empty !== 1'b1 || ras_top !== 10'h000) begin errors++; $display("FAIL ret_empty got empty=%b top=%h expected 1 000", ras_empty, ras_top); end
      call = 1'b1; step(); idle();
      checks++; if (pc !== 10'h012 || ras_empty !== 1'b1) begin errors++; $display("FAIL bare_call got pc=%h empty=%b expected 012 1", pc, ras_empty); end
   endtask

   task automatic test_overflow();
      logic [9:0] exp_ret [4];
      exp_ret[0] = 10'h051; exp_ret[1] = 10'h041; exp_ret[2] = 10'h031; exp_ret[3] = 10'h021;
      for (int i = 1; i <= 5; i++) begin
         jump(10'(i * 16), 1'b0);
         jump(10'h200, 1'b1);
         if (i == 4) begin
            checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0) begin errors++; $display("FAIL ovf_four got full=%b ovf=%b expected 1 0", ras_full, ras_ovf); end
         end
      end
      checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_five got full=%b ovf=%b expected 1 1", ras_full, ras_ovf); end
      checks++; if (ras_top !== 10'h051) begin errors++; $display("FAIL ovf_top got %h expected 051", ras_top); end
      for (int i = 0; i < 4; i++) begin
         ret = 1'b1; step(); idle();
         checks++; if (pc !== exp_ret[i]) begin errors++; $display("FAIL ovf_pop got %h expected %h", pc, exp_ret[i]); end
      end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got empty=%b expected 1", ras_empty); end
   endtask

   task automatic test_underflow_priority();
      jump(10'h007, 1'b0);
      checks++; if (ras_udf !== 1'b0) begin errors++; $display("FAIL udf_pre got %b expected 0", ras_udf); end
      ret = 1'b1; step(); idle();
      checks++; if (pc !== 10'h008 || ras_udf !== 1'b1) begin errors++; $display("FAIL udf got pc=%h udf=%b expected 008 1", pc, ras_udf); end
      jump(10'h020, 1'b1);
      checks++; if (ras_top !== 10'h009) begin errors++; $display("FAIL prio_setup got %h expected 009", ras_top); end
      exc = 1'b1; load_pc = 1'b1; call = 1'b1; ret = 1'b1; pc_new = 10'h155; step(); idle();
      checks++; if (pc !== 10'h3F0) begin errors++; $display("FAIL prio_pc got %h expected 3f0", pc); end
      checks++; if (ras_empty !== 1'b1 || ras_top !== 10'h000) begin errors++; $display("FAIL prio_flush got empty=%b top=%h expected 1 000", ras_empty, ras_top); end
      checks++; if (ras_udf !== 1'b1 || ras_ovf !== 1'b1) begin errors++; $display("FAIL prio_sticky got udf=%b ovf=%b expected 1 1", ras_udf, ras_ovf); end
   endtask

   task automatic test_wrap_reset();
      jump(10'h3FF, 1'b0);
      checks++; if (pc_4 !== 10'h000) begin errors++; $display("FAIL wrap_pc4 got %h expected 000", pc_4); end
      jump(10'h100, 1'b1);
      checks++; if (pc !== 10'h100 || ras_top !== 10'h000 || ras_empty !== 1'b0) begin errors++; $display("FAIL wrap_push got pc=%h top=%h empty=%b expected 100 000 0", pc, ras_top, ras_empty); end
      rst = 1'b1; step(); idle();
      checks++; if (pc !== 10'h000 || ras_empty !== 1'b1) begin errors++; $display("FAIL mid_reset got pc=%h empty=%b expected 000 1", pc, ras_empty); end
      checks++; if (ras_ovf !== 1'b0 || ras_udf !== 1'b0) begin errors++; $display("FAIL mid_reset_sticky got ovf=%b udf=%b expected 0 0", ras_ovf, ras_udf); end
   endtask

   initial begin
      idle();
      test_reset();
      test_run();
      test_stall();
      test_call_ret();
      test_overflow();
      test_underflow_priority();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
